cache_ctrl_burst: RTL and testbench

Parametrised control unit for the direct-mapped cache in front of the RAM. It replaces the single-word load controller with multi-word line refill and optional write-back eviction of dirty victims. It talks to memory through a per-word req/ack handshake and keeps a saturating miss counter. It sits between the processor-side start/address interface, the tag/data arrays (hit, dirty and victim_tag in; wrEn and tag_wrEn out) and the RAM.

---
 rtl/cache_pkg.sv | 24 ++
 rtl/burst_counter.sv | 36 +++
 rtl/cache_ctrl_burst.sv | 117 +++++++++++
 tb/tb_cache_ctrl_burst.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache: controller state encoding and
// geometry helpers used by the controller, the tag array and their benches.
package cache_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StLookup = 3'd2,
        StEvict  = 3'd3,
        StRefill = 3'd4,
        StUpdate = 3'd5
    } cache_state_e;

    function automatic int unsigned tag_width(input int unsigned addr_w,
                                              input int unsigned index_w,
                                              input int unsigned offset_w);
        return addr_w - index_w - offset_w;
    endfunction

    function automatic int unsigned line_words(input int unsigned offset_w);
        return 32'd1 << offset_w;
    endfunction

endpackage

// File: rtl/burst_counter.sv
// Beat counter for line bursts: synchronous clear, advance on each accepted word,
// flags the final beat of the line so the caller can leave the burst state.
module burst_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             last_o
);

    logic [WIDTH-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + WIDTH'(1);  // wraps to 0 after the last beat
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = &cnt_q;

endmodule

// File: rtl/cache_ctrl_burst.sv
// Direct-mapped cache controller: line refill bursts, optional write-back of dirty
// victims, per-word req/ack memory handshake and a saturating miss counter.
module cache_ctrl_burst
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned INDEX_W    = 7,
    parameter int unsigned OFFSET_W   = 2,
    parameter bit          WRITE_BACK = 1'b1,
    parameter int unsigned MISS_CNT_W = 16,
    parameter int unsigned TAG_W      = tag_width(ADDR_W, INDEX_W, OFFSET_W)
) (
    input  logic                  globalclock_i,
    input  logic                  reset_ni,
    input  logic                  start_i,
    input  logic [ADDR_W-1:0]     address_i,
    input  logic                  hit_i,
    input  logic                  dirty_i,
    input  logic [TAG_W-1:0]      victim_tag_i,
    input  logic                  mem_ack_i,
    output logic                  done_o,
    output logic                  busy_o,
    output logic                  wr_en_o,
    output logic                  tag_wr_en_o,
    output logic                  mem_rd_req_o,
    output logic                  mem_wr_req_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [OFFSET_W-1:0]   word_cnt_o,
    output logic [MISS_CNT_W-1:0] miss_count_o
);

    cache_state_e          state_d, state_q;
    logic [ADDR_W-1:0]     addr_d, addr_q;
    logic [MISS_CNT_W-1:0] miss_cnt_d, miss_cnt_q;
    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_W-1:0]    req_index;
    logic                  beat_clr, beat_inc, beat_last;

    assign req_tag   = addr_q[ADDR_W-1 -: TAG_W];
    assign req_index = addr_q[OFFSET_W +: INDEX_W];

    assign beat_clr = (state_q == StLookup);
    assign beat_inc = ((state_q == StEvict) || (state_q == StRefill)) && mem_ack_i;

    burst_counter #(
        .WIDTH (OFFSET_W)
    ) u_burst_counter (
        .clk_i  (globalclock_i),
        .rst_ni (reset_ni),
        .clr_i  (beat_clr),
        .inc_i  (beat_inc),
        .cnt_o  (word_cnt_o),
        .last_o (beat_last)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        miss_cnt_d = miss_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StStart;
            end
            StStart: begin
                addr_d = address_i;
                if (!start_i) state_d = StLookup;
            end
            StLookup: begin
                if (hit_i) begin
                    state_d = StIdle;
                end else begin
                    if (!(&miss_cnt_q)) miss_cnt_d = miss_cnt_q + MISS_CNT_W'(1);
                    state_d = (WRITE_BACK && dirty_i) ? StEvict : StRefill;
                end
            end
            StEvict: begin
                if (mem_ack_i && beat_last) state_d = StRefill;
            end
            StRefill: begin
                if (mem_ack_i && beat_last) state_d = StUpdate;
            end
            StUpdate: state_d = StLookup;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge globalclock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Everything but the data write strobe decodes from state alone.
    always_comb begin
        mem_addr_o = '0;
        if (state_q == StEvict) begin
            mem_addr_o = {victim_tag_i, req_index, word_cnt_o};
        end else if (state_q == StRefill) begin
            mem_addr_o = {req_tag, req_index, word_cnt_o};
        end
    end

    assign done_o       = (state_q == StIdle);
    assign busy_o       = (state_q != StIdle);
    assign mem_wr_req_o = (state_q == StEvict);
    assign mem_rd_req_o = (state_q == StRefill);
    assign wr_en_o      = (state_q == StRefill) && mem_ack_i;
    assign tag_wr_en_o  = (state_q == StUpdate);
    assign miss_count_o = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl_burst.sv
// Directed bench for cache_ctrl_burst: default instance plus WRITE_BACK=0 and
// 2-bit miss counter variants driven from the same stimulus.
module tb_cache_ctrl_burst;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [14:0] address;
    logic        hit;
    logic        dirty;
    logic [5:0]  victim_tag;
    logic        mem_ack;

    logic        done, busy, wr_en, tag_wr_en, rd_req, wr_req;
    logic [14:0] mem_addr;
    logic [1:0]  word_cnt;
    logic [15:0] miss_count;

    logic        nw_done, nw_busy, nw_wr_en, nw_tag_wr_en, nw_rd_req, nw_wr_req;
    logic [14:0] nw_mem_addr;
    logic [1:0]  nw_word_cnt;
    logic [15:0] nw_miss_count;

    logic        sc_done, sc_busy, sc_wr_en, sc_tag_wr_en, sc_rd_req, sc_wr_req;
    logic [14:0] sc_mem_addr;
    logic [1:0]  sc_word_cnt;
    logic [1:0]  sc_miss_count;

    int checks = 0;
    int errors = 0;

    cache_ctrl_burst u_dut (
        .globalclock_i (clk),        .reset_ni     (rst_n),
        .start_i       (start),      .address_i    (address),
        .hit_i         (hit),        .dirty_i      (dirty),
        .victim_tag_i  (victim_tag), .mem_ack_i    (mem_ack),
        .done_o        (done),       .busy_o       (busy),
        .wr_en_o       (wr_en),      .tag_wr_en_o  (tag_wr_en),
        .mem_rd_req_o  (rd_req),     .mem_wr_req_o (wr_req),
        .mem_addr_o    (mem_addr),   .word_cnt_o   (word_cnt),
        .miss_count_o  (miss_count)
    );

    cache_ctrl_burst #(.WRITE_BACK(1'b0)) u_dut_nowb (
        .globalclock_i (clk),          .reset_ni     (rst_n),
        .start_i       (start),        .address_i    (address),
        .hit_i         (hit),          .dirty_i      (dirty),
        .victim_tag_i  (victim_tag),   .mem_ack_i    (mem_ack),
        .done_o        (nw_done),      .busy_o       (nw_busy),
        .wr_en_o       (nw_wr_en),     .tag_wr_en_o  (nw_tag_wr_en),
        .mem_rd_req_o  (nw_rd_req),    .mem_wr_req_o (nw_wr_req),
        .mem_addr_o    (nw_mem_addr),  .word_cnt_o   (nw_word_cnt),
        .miss_count_o  (nw_miss_count)
    );

    cache_ctrl_burst #(.MISS_CNT_W(2)) u_dut_sat (
        .globalclock_i (clk),          .reset_ni     (rst_n),
        .start_i       (start),        .address_i    (address),
        .hit_i         (hit),          .dirty_i      (dirty),
        .victim_tag_i  (victim_tag),   .mem_ack_i    (mem_ack),
        .done_o        (sc_done),      .busy_o       (sc_busy),
        .wr_en_o       (sc_wr_en),     .tag_wr_en_o  (sc_tag_wr_en),
        .mem_rd_req_o  (sc_rd_req),    .mem_wr_req_o (sc_wr_req),
        .mem_addr_o    (sc_mem_addr),  .word_cnt_o   (sc_word_cnt),
        .miss_count_o  (sc_miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; hit = 1'b0; dirty = 1'b0; mem_ack = 1'b0;
        #1;
        step();
        rst_n = 1'b1;
        step();
    endtask

    // IDLE -> START (held start_cycles edges) -> LOOKUP; returns in LOOKUP.
    task automatic run_to_lookup(input int start_cycles);
        start   = 1'b1;
        address = 15'h1A5C;
        for (int i = 0; i < start_cycles; i++) step();
        start = 1'b0;
        step();
    endtask

    logic ack_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int   exp_cnt;

    initial begin
        address    = 15'h0;
        victim_tag = 6'h21;
        do_reset();
        check_eq("rst_done", {31'd0, done}, 32'd1);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_miss", {16'd0, miss_count}, 32'd0);
        check_eq("rst_addr", {17'd0, mem_addr}, 32'd0);

        // Hit after 3 cycles of start
        run_to_lookup(3);
        hit = 1'b1;
        #1;
        check_eq("hit_lookup_busy", {31'd0, busy}, 32'd1);
        check_eq("hit_lookup_req", {30'd0, rd_req, wr_req}, 32'd0);
        step();
        check_eq("hit_idle_done", {31'd0, done}, 32'd1);
        check_eq("hit_miss_cnt", {16'd0, miss_count}, 32'd0);

        // Clean miss, zero-wait memory
        hit = 1'b0; dirty = 1'b0;
        run_to_lookup(1);
        mem_ack = 1'b1;
        step();
        for (int b = 0; b < 4; b++) begin
            check_eq("clean_rd_req", {31'd0, rd_req}, 32'd1);
            check_eq("clean_wr_en", {31'd0, wr_en}, 32'd1);
            check_eq("clean_word_cnt", {30'd0, word_cnt}, b);
            check_eq("clean_addr", {17'd0, mem_addr}, 32'h1A5C + b);
            step();
        end
        check_eq("clean_tag_wr", {31'd0, tag_wr_en}, 32'd1);
        check_eq("clean_upd_wr_en", {31'd0, wr_en}, 32'd0);
        hit = 1'b1;
        step();
        check_eq("clean_relookup_tag_wr", {31'd0, tag_wr_en}, 32'd0);
        check_eq("clean_relookup_busy", {31'd0, busy}, 32'd1);
        step();
        check_eq("clean_done", {31'd0, done}, 32'd1);
        check_eq("clean_miss_cnt", {16'd0, miss_count}, 32'd1);

        // Dirty miss with write-back: evict victim line, then refill
        do_reset();
        run_to_lookup(1);
        hit = 1'b0; dirty = 1'b1; mem_ack = 1'b1;
        step();
        for (int b = 0; b < 4; b++) begin
            check_eq("evict_wr_req", {30'd0, wr_req, rd_req}, 32'd2);
            check_eq("evict_wr_en", {31'd0, wr_en}, 32'd0);
            check_eq("evict_addr", {17'd0, mem_addr}, 32'h425C + b);
            step();
        end
        for (int b = 0; b < 4; b++) begin
            check_eq("wb_refill_req", {30'd0, wr_req, rd_req}, 32'd1);
            check_eq("wb_refill_addr", {17'd0, mem_addr}, 32'h1A5C + b);
            step();
        end
        check_eq("wb_tag_wr", {31'd0, tag_wr_en}, 32'd1);

        // Dirty miss with write-back disabled: straight to refill
        do_reset();
        run_to_lookup(1);
        hit = 1'b0; dirty = 1'b1; mem_ack = 1'b1;
        step();
        for (int b = 0; b < 4; b++) begin
            check_eq("nowb_req", {30'd0, nw_wr_req, nw_rd_req}, 32'd1);
            check_eq("nowb_addr", {17'd0, nw_mem_addr}, 32'h1A5C + b);
            step();
        end
        check_eq("nowb_tag_wr", {31'd0, nw_tag_wr_en}, 32'd1);
        check_eq("nowb_no_wr_req", {31'd0, nw_wr_req}, 32'd0);

        // Wait states during refill
        do_reset();
        run_to_lookup(1);
        hit = 1'b0; dirty = 1'b0; mem_ack = 1'b0;
        step();
        exp_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            mem_ack = ack_pat[i];
            #1;
            check_eq("ws_rd_req", {31'd0, rd_req}, 32'd1);
            check_eq("ws_wr_en", {31'd0, wr_en}, {31'd0, ack_pat[i]});
            check_eq("ws_word_cnt", {30'd0, word_cnt}, exp_cnt);
            if (ack_pat[i]) exp_cnt++;
            step();
        end
        check_eq("ws_tag_wr", {31'd0, tag_wr_en}, 32'd1);

        // Reset mid-refill at beat 2
        do_reset();
        run_to_lookup(1);
        mem_ack = 1'b1;
        step();
        step();
        step();
        check_eq("pre_rst_word_cnt", {30'd0, word_cnt}, 32'd2);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_done", {31'd0, done}, 32'd1);
        check_eq("mid_rst_rd_req", {31'd0, rd_req}, 32'd0);
        check_eq("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
        check_eq("mid_rst_word_cnt", {30'd0, word_cnt}, 32'd0);
        check_eq("mid_rst_miss", {16'd0, miss_count}, 32'd0);
        step();
        rst_n = 1'b1;
        mem_ack = 1'b0;
        step();

        // Five clean misses: 16-bit counter reaches 5, 2-bit counter saturates at 3
        for (int m = 0; m < 5; m++) begin
            hit = 1'b0; dirty = 1'b0;
            run_to_lookup(1);
            mem_ack = 1'b1;
            for (int b = 0; b < 5; b++) step();
            hit = 1'b1;
            step();
            step();
            mem_ack = 1'b0;
        end
        check_eq("sat_done", {31'd0, done}, 32'd1);
        check_eq("sat_miss_wide", {16'd0, miss_count}, 32'd5);
        check_eq("sat_miss_narrow", {30'd0, sc_miss_count}, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
